// File: rtl/dcache_pkg.sv
// Shared types for the direct-mapped write-through L1 data cache:
// FSM state encoding, line layout and address-field width helpers.
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MEM_RD,
        MEM_WR,
        DONE
    } state_t;

    // Tags are carried at full width in line_t; only the low TAG_W bits are meaningful.
    localparam int MAX_TAG_W = 64;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [63:0]          data;
    } line_t;

    function automatic int idx_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int addr_w, input int num_lines);
        return addr_w - 3 - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the cache: one combinational read port,
// one synchronous write port, and a synchronous clear of all valid bits.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = 6,
    parameter int TAG_W     = 55
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output line_t            rd_line,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [63:0]      wr_data,
    input  logic             wr_valid
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [63:0]          data_q [NUM_LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data need no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_line                  = '0;
        rd_line.valid            = valid_q[rd_idx];
        rd_line.tag[TAG_W-1:0]   = tag_q[rd_idx];
        rd_line.data             = data_q[rd_idx];
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a
// single-beat backing-memory bus and saturating hit/miss counters.
//
//   state  | meaning
//   IDLE   | waiting for cache_enable; latch the request
//   CHECK  | tag compare; load hit completes, otherwise start a memory access
//   MEM_RD | load miss outstanding; refill line and return data on mem_ready
//   MEM_WR | write-through outstanding; complete on mem_ready
//   DONE   | completion pulse cycle; cache_enable ignored to avoid re-issue
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int ADDR_W    = 64,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_enable,
    input  logic              cache_wr_en,
    input  logic [ADDR_W-1:0] cache_wr_addr,
    input  logic [ADDR_W-1:0] cache_rd_addr,
    input  logic [63:0]       cache_wr_value,
    output logic [63:0]       cache_data,
    output logic              cache_operation_complete,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W = idx_width(NUM_LINES);
    localparam int TAG_W = tag_width(ADDR_W, NUM_LINES);

    state_t            state_q, state_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       cache_data_q, cache_data_d;
    logic              complete_q, complete_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [CNT_W-1:0]  miss_q, miss_d;

    line_t             rd_line;
    logic              arr_wr_en;
    logic [63:0]       arr_wr_data;
    logic [IDX_W-1:0]  addr_idx;
    logic [TAG_W-1:0]  addr_tag;
    logic              line_hit;
    logic [ADDR_W-1:0] addr_aligned;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign addr_idx     = addr_q[3 +: IDX_W];
    assign addr_tag     = addr_q[ADDR_W-1 -: TAG_W];
    assign addr_aligned = {addr_q[ADDR_W-1:3], 3'b000};
    assign line_hit     = rd_line.valid && (rd_line.tag[TAG_W-1:0] == addr_tag);

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (addr_idx),
        .rd_line  (rd_line),
        .wr_en    (arr_wr_en),
        .wr_idx   (addr_idx),
        .wr_tag   (addr_tag),
        .wr_data  (arr_wr_data),
        .wr_valid (1'b1)
    );

    always_comb begin
        state_d      = state_q;
        op_we_d      = op_we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cache_data_d = cache_data_q;
        complete_d   = complete_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        arr_wr_en    = 1'b0;
        arr_wr_data  = wdata_q;

        case (state_q)
            IDLE: begin
                if (cache_enable) begin
                    op_we_d = cache_wr_en;
                    addr_d  = cache_wr_en ? cache_wr_addr : cache_rd_addr;
                    wdata_d = cache_wr_value;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!op_we_q && line_hit) begin
                    cache_data_d = rd_line.data;
                    complete_d   = 1'b1;
                    hit_d        = sat_inc(hit_q);
                    state_d      = DONE;
                end else begin
                    // Every store goes through to memory; only a store hit also updates the line.
                    mem_req_d  = 1'b1;
                    mem_we_d   = op_we_q;
                    mem_addr_d = addr_aligned;
                    if (op_we_q) begin
                        mem_wdata_d = wdata_q;
                        arr_wr_en   = line_hit;
                        state_d     = MEM_WR;
                    end else begin
                        state_d = MEM_RD;
                    end
                    if (line_hit) begin
                        hit_d = sat_inc(hit_q);
                    end else begin
                        miss_d = sat_inc(miss_q);
                    end
                end
            end
            MEM_RD: begin
                if (mem_ready) begin
                    arr_wr_en    = 1'b1;
                    arr_wr_data  = mem_rdata;
                    cache_data_d = mem_rdata;
                    complete_d   = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = DONE;
                end
            end
            MEM_WR: begin
                if (mem_ready) begin
                    complete_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                complete_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_we_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cache_data_q <= '0;
            complete_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            op_we_q      <= op_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cache_data_q <= cache_data_d;
            complete_q   <= complete_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    assign cache_data               = cache_data_q;
    assign cache_operation_complete = complete_q;
    assign mem_req                  = mem_req_q;
    assign mem_we                   = mem_we_q;
    assign mem_addr                 = mem_addr_q;
    assign mem_wdata                = mem_wdata_q;
    assign hit_count                = hit_q;
    assign miss_count               = miss_q;

    // Byte-offset bits and the padding above TAG_W in line_t carry no information.
    logic unused_bits;
    assign unused_bits = ^{addr_q[2:0], rd_line.tag};

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: directed scenarios followed by random
// loads/stores, checked by a scoreboard against a behavioural cache/memory model.
module tb_dcache_direct;

    localparam int NL    = 64;
    localparam int AW    = 64;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              cache_enable;
    logic              cache_wr_en;
    logic [AW-1:0]     cache_wr_addr;
    logic [AW-1:0]     cache_rd_addr;
    logic [63:0]       cache_wr_value;
    logic [63:0]       cache_data;
    logic              cache_operation_complete;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    dcache_direct #(.NUM_LINES(NL), .ADDR_W(AW), .CNT_W(CNT_W)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .cache_enable             (cache_enable),
        .cache_wr_en              (cache_wr_en),
        .cache_wr_addr            (cache_wr_addr),
        .cache_rd_addr            (cache_rd_addr),
        .cache_wr_value           (cache_wr_value),
        .cache_data               (cache_data),
        .cache_operation_complete (cache_operation_complete),
        .mem_req                  (mem_req),
        .mem_we                   (mem_we),
        .mem_addr                 (mem_addr),
        .mem_wdata                (mem_wdata),
        .mem_rdata                (mem_rdata),
        .mem_ready                (mem_ready),
        .hit_count                (hit_count),
        .miss_count               (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [63:0] mm [logic [63:0]];
    bit          rv [NL];
    logic [63:0] rt [NL];
    int          exp_hits, exp_misses;
    logic [63:0] last_load;

    typedef struct {
        bit          is_load;
        logic [63:0] data;
        int          hits;
        int          misses;
        int          accesses;
    } exp_t;
    exp_t sbq [$];

    function automatic logic [63:0] mm_read(input logic [63:0] a);
        if (mm.exists(a)) return mm[a];
        return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) rv[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        last_load  = '0;
    endfunction

    // Current transaction, as seen by the memory responder.
    bit          cur_we;
    logic [63:0] cur_aligned;
    logic [63:0] cur_wdata;
    int          fixed_delay;
    bit          hold_mem;
    int          mem_acc;

    // ---------------- backing memory responder ----------------
    initial begin
        logic [63:0] a;
        int          wait_n;
        mem_ready = 1'b0;
        mem_rdata = '0;
        mem_acc   = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (rst || !mem_req) continue;
            chk("mem_we", {63'b0, mem_we}, {63'b0, cur_we});
            chk("mem_addr", mem_addr, cur_aligned);
            if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
            a = mem_addr;
            mem_acc++;
            wait_n = (fixed_delay > 0) ? fixed_delay - 1 : int'($urandom_range(0, 3));
            for (int k = 0; k < wait_n && !rst; k++) begin
                @(negedge clk);
                if (!rst) chk("mem_addr_stable", {mem_req, mem_addr[62:0]}, {1'b1, a[62:0]});
            end
            for (int k = 0; k < 400 && hold_mem && !rst; k++) @(negedge clk);
            if (rst) continue;
            if (mem_we) mm[a] = mem_wdata;
            else mem_rdata = mm_read(a);
            mem_ready = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int   acc_snap;
        bit   prev_c;
        exp_t e;
        acc_snap = 0;
        prev_c   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_snap = mem_acc;
            end else if (cache_operation_complete) begin
                if (prev_c) chk("complete_pulse_width", 64'd1, 64'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_complete", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk(e.is_load ? "load_data" : "store_keeps_cache_data", cache_data, e.data);
                    chk("hit_count", 64'(hit_count), 64'(e.hits));
                    chk("miss_count", 64'(miss_count), 64'(e.misses));
                    chk("mem_accesses", 64'(mem_acc - acc_snap), 64'(e.accesses));
                end
                acc_snap = mem_acc;
            end
            prev_c = cache_operation_complete;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = (64'($urandom_range(0, 3)) << 9) | (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) a[47] = 1'b1;
        return a;
    endfunction

    task automatic do_req(input bit we, input logic [63:0] addr, input logic [63:0] val);
        int          idx;
        logic [63:0] tag;
        bit          hit;
        exp_t        e;
        int          cycles;
        bit          seen;
        idx = int'((addr >> 3) % NL);
        tag = addr >> 9;
        hit = rv[idx] && (rt[idx] == tag);
        if (hit) exp_hits = (exp_hits < CMAX) ? exp_hits + 1 : CMAX;
        else exp_misses = (exp_misses < CMAX) ? exp_misses + 1 : CMAX;
        if (!we) begin
            if (!hit) begin
                rv[idx] = 1'b1;
                rt[idx] = tag;
            end
            last_load = mm_read({addr[63:3], 3'b000});
        end
        e.is_load  = !we;
        e.data     = last_load;
        e.hits     = exp_hits;
        e.misses   = exp_misses;
        e.accesses = (we || !hit) ? 1 : 0;
        sbq.push_back(e);
        cur_we      = we;
        cur_aligned = {addr[63:3], 3'b000};
        cur_wdata   = val;

        @(negedge clk);
        cache_enable   = 1'b1;
        cache_wr_en    = we;
        cache_wr_addr  = we ? addr : {$urandom, $urandom};
        cache_rd_addr  = we ? {$urandom, $urandom} : addr;
        cache_wr_value = val;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 200) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            seen = cache_operation_complete;
            // Request inputs are scrambled once accepted; the cache must use its latched copy.
            cache_wr_en    = $urandom_range(0, 1) == 1;
            cache_wr_addr  = {$urandom, $urandom};
            cache_rd_addr  = {$urandom, $urandom};
            cache_wr_value = {$urandom, $urandom};
        end
        if (!seen) chk("complete_timeout", 64'd0, 64'd1);
        if (!we && hit) chk("load_hit_latency", 64'(cycles), 64'd2);
        @(posedge clk);
        @(negedge clk);
        cache_enable = 1'b0;
    endtask

    initial begin
        bit seen_req;
        rst            = 1'b1;
        cache_enable   = 1'b0;
        cache_wr_en    = 1'b0;
        cache_wr_addr  = '0;
        cache_rd_addr  = '0;
        cache_wr_value = '0;
        fixed_delay    = 3;
        hold_mem       = 1'b0;
        cur_we         = 1'b0;
        cur_aligned    = '0;
        cur_wdata      = '0;
        model_reset();
        mm[64'h1000] = 64'hDEADBEEF_CAFEF00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cache_data", cache_data, 64'd0);
        chk("rst_complete", {63'b0, cache_operation_complete}, 64'd0);
        chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_hit_count", 64'(hit_count), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
        rst = 1'b0;

        do_req(1'b0, 64'h1000, 64'h0);
        do_req(1'b0, 64'h1000, 64'h0);
        do_req(1'b1, 64'h1000, 64'h1111);
        do_req(1'b0, 64'h1000, 64'h0);
        do_req(1'b0, 64'h1200, 64'h0);
        do_req(1'b0, 64'h1000, 64'h0);
        do_req(1'b1, 64'h2008, 64'h2222_3333_4444_5555);
        do_req(1'b0, 64'h2008, 64'h0);

        // Reset while a load miss is waiting on memory.
        hold_mem    = 1'b1;
        cur_we      = 1'b0;
        cur_aligned = 64'h3000;
        @(negedge clk);
        cache_enable  = 1'b1;
        cache_wr_en   = 1'b0;
        cache_rd_addr = 64'h3000;
        seen_req = 1'b0;
        for (int k = 0; k < 20 && !seen_req; k++) begin
            @(negedge clk);
            seen_req = mem_req;
        end
        chk("rst_test_mem_req_seen", {63'b0, seen_req}, 64'd1);
        @(negedge clk);
        rst          = 1'b1;
        cache_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_mem_req", {63'b0, mem_req}, 64'd0);
        chk("midrst_complete", {63'b0, cache_operation_complete}, 64'd0);
        chk("midrst_hit_count", 64'(hit_count), 64'd0);
        chk("midrst_miss_count", 64'(miss_count), 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        hold_mem = 1'b0;
        model_reset();
        @(negedge clk);
        chk("post_rst_complete", {63'b0, cache_operation_complete}, 64'd0);
        do_req(1'b0, 64'h1000, 64'h0);

        fixed_delay = 0;
        for (int n = 0; n < 250; n++) begin
            bit w;
            w = ($urandom_range(0, 2) == 0);
            do_req(w, rand_addr(), {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache sitting directly downstream of the memory pipeline stage.
- Consumes that stage's cache_enable / cache_wr_en / cache_wr_addr / cache_rd_addr / cache_wr_value request.
- Returns cache_data with a one-cycle cache_operation_complete pulse.
- Talks to backing memory over a simple single-beat req/ready bus and keeps hit/miss statistics.

Parameters:
NUM_LINES, 64, number of lines (power of two); each line holds one aligned 64-bit word
ADDR_W, 64, request address width
CNT_W, 32, width of hit/miss counters

Ports:
clk  in  1  clock
rst  in  1  reset
cache_enable  in  1  request valid; held high by requester until it samples complete
cache_wr_en  in  1  1 = store, 0 = load
cache_wr_addr  in  ADDR_W  store address
cache_rd_addr  in  ADDR_W  load address
cache_wr_value  in  64  store data
cache_data  out  64  load result, registered
cache_operation_complete  out  1  one-cycle completion pulse
mem_req  out  1  backing-memory request, held until mem_ready
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  8-byte aligned address
mem_wdata  out  64  write data
mem_rdata  in  64  read data, valid with mem_ready
mem_ready  in  1  one-cycle accept/complete pulse; only meaningful while mem_req=1
hit_count  out  CNT_W  saturating load+store hit counter
miss_count  out  CNT_W  saturating load+store miss counter

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset, all valid bits clear; FSM goes to IDLE.
  - Outputs reset to 0: cache_data, cache_operation_complete, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count.
- Address decode:
  - Request address is cache_wr_addr if cache_wr_en, else cache_rd_addr.
  - addr[2:0] ignored. index = addr[3 +: IDX_W], IDX_W = log2(NUM_LINES). tag = addr[ADDR_W-1 : 3+IDX_W].
- FSM states: IDLE, CHECK, MEM_RD, MEM_WR, DONE.
- IDLE: if cache_enable=1 at edge N, latch op/addr/wdata; go to CHECK.
- CHECK (edge N+1):
  - Load hit: cache_data <= line data; complete <= 1; hit_count++; go to DONE. Complete is visible in the cycle after N+1, so load-hit latency is 2 edges.
  - Load miss: mem_req <= 1, mem_we <= 0, mem_addr <= aligned addr; miss_count++; go to MEM_RD.
  - Store hit: line data <= wdata; hit_count++; mem_req <= 1, mem_we <= 1, mem_wdata <= wdata; go to MEM_WR.
  - Store miss: same mem write, line untouched (no allocate); miss_count++; go to MEM_WR.
- MEM_RD: wait for mem_ready. On mem_ready:
  - Fill line (valid=1, tag, data = mem_rdata).
  - cache_data <= mem_rdata; complete <= 1; mem_req <= 0; go to DONE.
- MEM_WR: on mem_ready, mem_req <= 0, complete <= 1, go to DONE. cache_data unchanged.
- DONE:
  - complete <= 0; go to IDLE. cache_enable is ignored here.
  - Reason: the requester's enable is registered and falls one cycle after it sees complete, so this prevents a re-issue.
  - Next request is accepted no earlier than the edge after DONE.
- cache_data holds its value until the next load completion.
- mem_req, mem_we, mem_addr and mem_wdata are stable from assertion until the mem_ready edge.
- Counters saturate at all-ones and do not wrap.
- Request input changes while FSM is not in IDLE are ignored; the latched copy is used.
- rst in any state: FSM to IDLE, mem_req=0 on the next cycle, no complete pulse, outstanding memory op abandoned. Backing memory shares rst and drops its outstanding op.
- mem_ready outside MEM_RD/MEM_WR is ignored.

Decomposition:
- dcache_pkg holds:
  - state enum (IDLE, CHECK, MEM_RD, MEM_WR, DONE)
  - function deriving IDX_W/TAG_W from NUM_LINES, ADDR_W
  - line struct {valid, tag, data}
- Sub-module dcache_array: valid/tag/data storage with one combinational read port (index), one synchronous write port (index, tag, data, valid), and synchronous clear-all on rst.
- Top-level dcache_direct holds the FSM, request latch and counters.

Test Plan:
- Reset, load 0x1000 -> mem_req=1, mem_we=0, mem_addr=0x1000; mem_ready after 3 cycles with rdata 0xDEADBEEF_CAFEF00D -> complete pulses exactly 1 cycle, cache_data=0xDEADBEEF_CAFEF00D, miss_count=1.
- Load 0x1000 again -> no mem_req; complete high in cycle after 2nd edge post-enable; cache_data=0xDEADBEEF_CAFEF00D; hit_count=1. Enable held 1 extra cycle after complete -> no second access, counters unchanged.
- Store 0x1000 value 0x1111 -> mem_req=1, mem_we=1, mem_wdata=0x1111; complete after mem_ready. Then load 0x1000 -> hit, cache_data=0x1111, no mem_req.
- Load 0x1200 (same index 0, different tag) -> miss and refill. Then load 0x1000 -> miss again (eviction), miss_count increments.
- Store to 0x2008 on cold line -> mem write, no allocate. Then load 0x2008 -> miss with mem_req.
- Load 0x3000, assert rst while in MEM_RD -> mem_req low the next cycle, no complete pulse, counters=0. Then load 0x1000 -> misses (valid bits cleared).
